// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg                                                           |
// | Shared constants and helpers for the UART transmit/receive blocks. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int c_BYTE_W = 8;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;

    // The timeout counter only has to reach TIMEOUT-1.
    function automatic int to_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick                                                            |
// | Rotate-priority picker: first valid index at or after rr_ptr.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int              c_IW = $clog2(N_REQ);
    localparam logic [c_IW:0]   c_N  = (c_IW+1)'(N_REQ);

    logic [c_IW:0] w_cand;

    // One extra bit of headroom so the wrap is an explicit compare, valid for any N_REQ.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, rr_ptr} + (c_IW+1)'(k);
            if (w_cand >= c_N) begin
                w_cand = w_cand - c_N;
            end
            if (!found && req_valid[w_cand[c_IW-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[c_IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_sched                                                      |
// | Packet-granular round-robin scheduler in front of the UART TX core.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [c_BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [c_BYTE_W-1:0]         tx_byte,
    output logic                        tx_valid,
    input  logic                        tx_done,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int c_IW   = $clog2(N_REQ);
    localparam int c_TO_W = to_cnt_width(TIMEOUT);

    logic [1:0]            r_state;
    logic [c_IW-1:0]       r_rr_ptr;
    logic [c_IW-1:0]       r_grant_id;
    logic [7:0]            r_burst_cnt;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic                  r_last_q;
    logic                  r_done_q;
    logic [c_BYTE_W-1:0]   r_tx_byte;
    logic                  r_tx_valid;
    logic                  r_timeout_err;

    logic                  w_found;
    logic [c_IW-1:0]       w_pick_idx;
    logic                  w_accept;
    logic                  w_done_edge;
    logic                  w_to_expired;
    logic                  w_pkt_end;
    logic [c_IW-1:0]       w_next_ptr;
    logic [c_BYTE_W-1:0]   w_sel_data;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .found     (w_found),
        .idx       (w_pick_idx)
    );

    assign w_accept     = (r_state == c_ST_ISSUE) && req_valid[r_grant_id];
    assign w_done_edge  = tx_done && !r_done_q;
    assign w_to_expired = (r_to_cnt == c_TO_W'(TIMEOUT-1));
    assign w_pkt_end    = r_last_q || (r_burst_cnt == 8'(MAX_BURST));
    assign w_next_ptr   = (r_grant_id == c_IW'(N_REQ-1)) ? '0 : r_grant_id + 1'b1;
    assign w_sel_data   = req_data[int'(r_grant_id)*c_BYTE_W +: c_BYTE_W];

    always_comb begin
        req_ready = '0;
        if (r_state == c_ST_ISSUE) begin
            req_ready[r_grant_id] = req_valid[r_grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_burst_cnt   <= '0;
            r_to_cnt      <= '0;
            r_last_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_tx_byte     <= '0;
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_q      <= tx_done;
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_found) begin
                        r_grant_id  <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    // A byte offered on the expiry cycle is still taken.
                    if (w_accept) begin
                        r_tx_byte   <= w_sel_data;
                        r_tx_valid  <= 1'b1;
                        r_last_q    <= req_last[r_grant_id];
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                        r_to_cnt    <= '0;
                        r_state     <= c_ST_WAIT_DONE;
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_to_cnt      <= '0;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (w_done_edge) begin
                        r_to_cnt <= '0;
                        if (w_pkt_end) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_state  <= c_ST_ISSUE;
                        end
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_to_cnt      <= '0;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_to_cnt <= '0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_byte     = r_tx_byte;
    assign tx_valid    = r_tx_valid;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != c_ST_IDLE);
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_sched                                                   |
// | Scoreboard bench: requester queues, core model, byte monitor.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_uart_tx_sched;

    typedef struct packed { logic [7:0] d; logic l; } src_t;
    typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    src_t src_q [4][$];
    exp_t exp_q [$];
    int   tx_cyc_q [$];
    int   rise_q [$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_delay = 3;
    int   to_seen = 0;
    int   to_cyc = 0;
    logic to_busy = 1'b0;
    logic prev_tv = 1'b0;
    logic [3:0] drv_acc;

    uart_tx_sched #(
        .N_REQ     (4),
        .MAX_BURST (4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic l);
        src_t s;
        s.d = d;
        s.l = l;
        src_q[r].push_back(s);
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id = 2'(id);
        e.d  = d;
        exp_q.push_back(e);
    endtask

    function automatic bit srcs_empty();
        return (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
               (src_q[2].size() == 0) && (src_q[3].size() == 0);
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                fail_now(name);
                return;
            end
        end while (!(busy == 1'b0 && tx_done == 1'b0 && exp_q.size() == 0 && srcs_empty()));
    endtask

    // Requester model: presents queue heads, retires a byte after a handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            drv_acc = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (drv_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = src_q[i][0].d;
                    req_last[i]         = src_q[i][0].l;
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*8 +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Core model: tx_done high for two cycles, done_delay cycles after each load.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid && rst_n) begin
                repeat (done_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                rise_q.push_back(cyc);
                repeat (2) @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every load strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tv = 1'b0;
                continue;
            end
            if (tx_valid) begin
                check("tx_valid_gap", 32'(prev_tv), 32'd0);
                tx_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_tx: got byte %0h from %0d expected none", tx_byte, grant_id);
                    n_chk++;
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(tx_byte), 32'(e.d));
                    check("tx_grant", 32'(grant_id), 32'(e.id));
                end
            end
            if (timeout_err) begin
                to_seen++;
                to_cyc  = cyc;
                to_busy = busy;
            end
            prev_tv = tx_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int to_before;
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single requester, latency and byte-to-byte spacing.
        tx_cyc_q.delete();
        rise_q.delete();
        push_exp(2, 8'hA5); push_exp(2, 8'h3C); push_exp(2, 8'h0F);
        push_src(2, 8'hA5, 1'b0); push_src(2, 8'h3C, 1'b0); push_src(2, 8'h0F, 1'b1);
        t0 = cyc;
        drain("single_drain");
        check("single_busy_end", 32'(busy), 32'd0);
        if (tx_cyc_q.size() >= 3 && rise_q.size() >= 2) begin
            check("single_first_latency", 32'(tx_cyc_q[0]), 32'(t0 + 2));
            check("single_b2b_1", 32'(tx_cyc_q[1]), 32'(rise_q[0] + 2));
            check("single_b2b_2", 32'(tx_cyc_q[2]), 32'(rise_q[1] + 2));
        end else begin
            fail_now("single_timing_samples");
        end

        // rr_ptr should now be 3: requester 3 wins over 2.
        tick();
        push_exp(3, 8'h31); push_exp(2, 8'h21);
        push_src(2, 8'h21, 1'b1); push_src(3, 8'h31, 1'b1);
        drain("ptr3_drain");
        tick();
        push_exp(3, 8'h32);
        push_src(3, 8'h32, 1'b1);
        drain("ptr_wrap_drain");

        // Contention, two rounds starting from rr_ptr = 0.
        tick();
        for (int r = 0; r < 4; r++) push_exp(r, 8'h40 + 8'(r));
        for (int r = 0; r < 4; r++) push_exp(r, 8'h50 + 8'(r));
        for (int r = 0; r < 4; r++) begin
            push_src(r, 8'h40 + 8'(r), 1'b1);
            push_src(r, 8'h50 + 8'(r), 1'b1);
        end
        drain("contention_drain");

        // Burst limit of 4 forces rotation to requester 3.
        tick();
        for (int k = 0; k < 4; k++) push_exp(1, 8'h60 + 8'(k));
        push_exp(3, 8'h70); push_exp(3, 8'h71);
        push_exp(1, 8'h64); push_exp(1, 8'h65);
        for (int k = 0; k < 6; k++) push_src(1, 8'h60 + 8'(k), (k == 5) ? 1'b1 : 1'b0);
        push_src(3, 8'h70, 1'b0); push_src(3, 8'h71, 1'b1);
        drain("burst_drain");

        // Done edge on the exact expiry cycle: no timeout, packet continues.
        tick();
        to_before = to_seen;
        done_delay = 15;
        push_exp(3, 8'h80); push_exp(3, 8'h81);
        push_src(3, 8'h80, 1'b0); push_src(3, 8'h81, 1'b1);
        drain("edge_vs_to_drain");
        check("edge_vs_to_no_err", 32'(to_seen), 32'(to_before));
        done_delay = 3;

        // Timeout after requester 0 abandons its packet.
        tick();
        rise_q.delete();
        to_before = to_seen;
        push_exp(0, 8'h90);
        push_src(0, 8'h90, 1'b0);
        drain("timeout_drain");
        check("timeout_count", 32'(to_seen), 32'(to_before + 1));
        if (rise_q.size() >= 1) begin
            check("timeout_cycle", 32'(to_cyc), 32'(rise_q[0] + 17));
        end else begin
            fail_now("timeout_rise_sample");
        end
        check("timeout_busy", 32'(to_busy), 32'd0);
        tick();
        push_exp(1, 8'hA1); push_exp(0, 8'h91);
        push_src(0, 8'h91, 1'b1); push_src(1, 8'hA1, 1'b1);
        drain("after_timeout_drain");

        // Reset while waiting for the core.
        tick();
        push_exp(2, 8'hB0);
        push_src(2, 8'hB0, 1'b0); push_src(2, 8'hB1, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 200);
        if (!tx_valid) fail_now("reset_wait_tx");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        push_exp(0, 8'hC0); push_exp(2, 8'hB1); push_exp(3, 8'hD0);
        push_src(0, 8'hC0, 1'b1); push_src(3, 8'hD0, 1'b1);
        repeat (4) tick();
        rst_n = 1'b1;
        drain("reset_drain");
        check("final_timeouts", 32'(to_seen), 32'd1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Shares the single transmit path of the UART core between `N_REQ` byte-stream requesters. Round-robin arbitration runs at packet granularity: a grant is held until the requester's `last` byte, a burst limit, or a timeout. One byte is issued to the core at a time, and the next byte waits for completion of the previous one. The block sits between the register/host logic and the core's `tx_byte`/`tx_valid`/`tx_done` ports.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: max bytes per grant before forced rotation (1..255).
- `TIMEOUT`, 4096: cycles allowed in ISSUE or WAIT_DONE before the grant is forcibly released (≥4).
- `clk` in 1: single clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in N_REQ: requester i has a byte.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in N_REQ: byte of requester i ends its packet.
- `req_ready` out N_REQ: byte of requester i accepted this cycle. One-hot or zero.
- `tx_byte` out 8: byte to the core.
- `tx_valid` out 1: one-cycle load strobe to the core.
- `tx_done` in 1: core level, high during the last data bit of a frame.
- `grant_id` out $clog2(N_REQ): current or most recent owner.
- `busy` out 1: a grant is active.
- `timeout_err` out 1: one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE
  - Pick the first i with `req_valid[i]`, searching cyclically from `rr_ptr`.
  - If found: latch `grant_id`=i, burst_cnt=0, go to ISSUE.
  - Else stay in IDLE.
- ISSUE
  - `req_ready[grant_id]` = `req_valid[grant_id]`, combinational; all other ready bits are 0.
  - On accept: register `tx_byte` = data, `tx_valid`=1 next cycle, latch last_q = `req_last`, increment burst_cnt, go to WAIT_DONE.
- WAIT_DONE
  - Wait for a rising edge of `tx_done` (`tx_done` & !done_q).
  - On that edge, if last_q or burst_cnt==MAX_BURST: `rr_ptr` = grant_id+1 mod N_REQ, go to IDLE.
  - Otherwise go to ISSUE.
- Timeout
  - to_cnt clears on every state entry and increments in ISSUE and WAIT_DONE.
  - When to_cnt reaches TIMEOUT-1: `timeout_err` pulse, `rr_ptr` = grant_id+1, go to IDLE.
  - A timed-out packet is not resumed. Its remaining bytes compete as a new packet.
- `rr_ptr` wraps from N_REQ-1 to 0. Non-power-of-two N_REQ uses explicit compare, not bit truncation.
- `busy` = (state != IDLE).
- Simultaneous requests: resolved only by `rr_ptr` order.
- A requester dropping `req_valid` mid-packet keeps the grant until timeout.
- The `tx_done` edge and the timeout expiring in the same cycle: the done edge wins, and no `timeout_err` is raised.
- A `req_valid` change during WAIT_DONE is ignored.

## Timing
- Reset values: `req_ready`=0, `tx_valid`=0, `tx_byte`=8'h00, `grant_id`=0, `busy`=0, `timeout_err`=0. Internally `rr_ptr`=0, done_q=0, state=IDLE.
- Reset is sampled at `clk` edge. Asserting it mid-frame returns to IDLE next edge with no `tx_valid`. A byte already loaded in the core is not recalled.
- Latency: `req_valid` high in IDLE at cycle t → `req_ready` high at t+1 → `tx_valid` at t+2.
- Byte-to-byte: `tx_done` rising edge at cycle d → ISSUE at d+1 → next `tx_valid` no earlier than d+2.
- `tx_valid` is never high in two consecutive cycles. It is never asserted while state is WAIT_DONE without a preceding accept.
- Handshake: a byte transfers when `req_valid` & `req_ready`. Requesters may not depend on `req_ready` to raise `req_valid`.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0, ISSUE=1, WAIT_DONE=2);
  - width helper for the timeout counter;
  - byte width constant 8.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs: `req_valid`, `rr_ptr`. Outputs: `found`, `idx`. It is also reused by the future RX distributor.
- Top-level FSM, burst counter, timeout counter, and done edge detector live in `uart_tx_sched`.

## Test plan
- Single requester: req 2 sends 3 bytes 8'hA5, 8'h3C, 8'h0F (last on the third); `tx_done` is pulsed by the model. Expect exactly 3 `tx_valid` pulses carrying those bytes in order, then `rr_ptr`=3 and `busy`=0.
- Contention: all 4 requesters assert single-byte packets at once with `rr_ptr`=0. Expect grant order 0,1,2,3, and a second round restarting at 0.
- Burst limit: MAX_BURST=4; req 1 sends 6 bytes without `last` while req 3 is also requesting. Expect 4 bytes from req 1, then req 3's packet, then the remaining 2 bytes from req 1.
- Timeout: TIMEOUT=16; req 0 sends one non-last byte and then drops `req_valid`. Expect `timeout_err` exactly 16 cycles after ISSUE entry, then `busy`=0 and `rr_ptr`=1.
- Edge vs timeout: the `tx_done` rising edge lands on the cycle the timeout expires. Expect no `timeout_err` and normal continuation.
- Reset mid-packet: deassert `rst_n` during WAIT_DONE. Expect all outputs at reset values on the next edge, and the first grant after release going to the lowest requesting index.
